// File: rtl/seg_scan_mux_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
// Segment order is {g,f,e,d,c,b,a}; table values are active-high.
package seg_scan_mux_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry n is the glyph for hex digit n (index 15 listed first).
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic an_active(input bit act_low);
    return act_low ? 1'b0 : 1'b1;
  endfunction

  function automatic logic an_idle(input bit act_low);
    return act_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Display-data and pin bundle between the score logic (master) and the scanner (slave).
interface seg_scan_mux_if #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BRIGHT_W   = 3
);
  logic                    enable;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   blank;
  logic [BRIGHT_W-1:0]     brightness;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_tick;

  modport master (
    output enable, digits, dp, blank, brightness,
    input  seg_n, dp_n, an, frame_tick
  );

  modport slave (
    input  enable, digits, dp, blank, brightness,
    output seg_n, dp_n, an, frame_tick
  );
endinterface

// File: rtl/seg_scan_mux_hex_to_seg7.sv
// Combinational hex nibble to active-high 7-segment glyph.
module hex_to_seg7
  import seg_scan_mux_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);
  assign seg_c = HEX7_TABLE[nibble];
endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment driver: prescaled digit scan, frame-coherent shadow
// capture, PWM brightness window with leading anti-ghost guard; all pins registered.
module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned SCAN_PERIOD = 100000,
  parameter int unsigned GUARD       = 16,
  parameter int unsigned BRIGHT_W    = 3,
  parameter bit          AN_ACT_LOW  = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  seg_scan_mux_if.slave bus
);

  localparam int unsigned CNT_W = ($clog2(SCAN_PERIOD) > 0) ? $clog2(SCAN_PERIOD) : 1;
  localparam int unsigned IDX_W = ($clog2(NUM_DIGITS) > 0) ? $clog2(NUM_DIGITS) : 1;
  // Wide enough for (2^BRIGHT_W) * SCAN_PERIOD before the shift.
  localparam int unsigned ON_W  = BRIGHT_W + 1 + $clog2(SCAN_PERIOD + 1);

  logic [CNT_W-1:0]           cnt;
  logic [IDX_W-1:0]           idx;
  logic [NUM_DIGITS-1:0][3:0] digits_sh;
  logic [NUM_DIGITS-1:0]      dp_sh;
  logic [NUM_DIGITS-1:0]      blank_sh;
  logic [BRIGHT_W-1:0]        bright_sh;

  logic [ON_W-1:0]            on_end_c;
  logic                       lit_c;
  logic                       slot_end_c;
  logic                       frame_end_c;
  logic [6:0]                 seg_hi_c;
  logic [NUM_DIGITS-1:0]      an_nxt_c;

  logic [6:0]                 seg_n_q;
  logic                       dp_n_q;
  logic [NUM_DIGITS-1:0]      an_q;
  logic                       frame_tick_q;

  hex_to_seg7 u_hex (
    .nibble (digits_sh[idx]),
    .seg_c  (seg_hi_c)
  );

  // Lit window and next anode pattern from the current scan position.
  always_comb begin
    on_end_c    = ON_W'(((ON_W'(bright_sh) + ON_W'(1)) * ON_W'(SCAN_PERIOD)) >> BRIGHT_W);
    lit_c       = bus.enable && !blank_sh[idx] &&
                  (ON_W'(cnt) >= ON_W'(GUARD)) && (ON_W'(cnt) < on_end_c);
    slot_end_c  = (cnt == CNT_W'(SCAN_PERIOD - 1));
    frame_end_c = slot_end_c && (idx == IDX_W'(NUM_DIGITS - 1));
    an_nxt_c    = {NUM_DIGITS{an_idle(AN_ACT_LOW)}};
    if (lit_c) an_nxt_c[idx] = an_active(AN_ACT_LOW);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt          <= '0;
      idx          <= '0;
      digits_sh    <= '0;
      dp_sh        <= '0;
      blank_sh     <= '0;
      bright_sh    <= '0;
      seg_n_q      <= SEG_OFF;
      dp_n_q       <= 1'b1;
      an_q         <= {NUM_DIGITS{an_idle(AN_ACT_LOW)}};
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= 1'b0;
      if (bus.enable) begin
        if (slot_end_c) begin
          cnt <= '0;
          if (frame_end_c) begin
            idx          <= '0;
            digits_sh    <= bus.digits;
            dp_sh        <= bus.dp;
            blank_sh     <= bus.blank;
            bright_sh    <= bus.brightness;
            frame_tick_q <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      an_q    <= an_nxt_c;
      seg_n_q <= lit_c ? ~seg_hi_c : SEG_OFF;
      dp_n_q  <= lit_c ? ~dp_sh[idx] : 1'b1;
    end
  end

  assign bus.seg_n      = seg_n_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomised bench for seg_scan_mux against a frame-position reference model.
module tb_seg_scan_mux;

  localparam int N  = 4;
  localparam int SP = 8;
  localparam int GD = 1;
  localparam int BW = 3;
  localparam int FRAME = N * SP;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  seg_scan_mux_if #(.NUM_DIGITS(N), .BRIGHT_W(BW)) bus ();

  seg_scan_mux #(
    .NUM_DIGITS (N), .SCAN_PERIOD(SP), .GUARD(GD), .BRIGHT_W(BW), .AN_ACT_LOW(1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Reference glyphs {g,f,e,d,c,b,a}, active-high.
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model: a single position within the frame plus captured frame data.
  int         m_pos;
  logic [3:0] m_dig [N];
  logic [N-1:0] m_dp, m_blank;
  int         m_bright;
  logic [12:0] exp_v;   // {an, seg_n, dp_n, frame_tick}
  int vectors = 0;
  int errors  = 0;

  function automatic logic [12:0] got_v();
    return {bus.an, bus.seg_n, bus.dp_n, bus.frame_tick};
  endfunction

  // Advance one clock: predict the pins after this edge, then step the model.
  task automatic tick();
    int d, c, on_end;
    logic lit, ft;
    if (!reset_n) begin
      exp_v = {4'hF, 7'h7F, 1'b1, 1'b0};
      m_pos = 0; m_dp = '0; m_blank = '0; m_bright = 0;
      for (int k = 0; k < N; k++) m_dig[k] = 4'h0;
    end else begin
      d      = m_pos / SP;
      c      = m_pos % SP;
      on_end = ((m_bright + 1) * SP) / (1 << BW);
      lit    = bus.enable && !m_blank[d] && (c >= GD) && (c < on_end);
      ft     = bus.enable && (m_pos == FRAME - 1);
      if (lit) exp_v = {4'(~(4'b0001 << d)), ~glyph[m_dig[d]], ~m_dp[d], ft};
      else     exp_v = {4'hF, 7'h7F, 1'b1, ft};
      if (bus.enable) m_pos = (m_pos + 1) % FRAME;
      if (ft) begin
        for (int k = 0; k < N; k++) m_dig[k] = bus.digits[4*k +: 4];
        m_dp = bus.dp; m_blank = bus.blank; m_bright = int'(bus.brightness);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.enable = 1'b1; bus.digits = 16'(32'($urandom)); bus.dp = 4'hF;
    bus.blank = 4'h0; bus.brightness = 3'd7;
    for (int i = 0; i < 3; i++) begin
      tick(); vectors++;
      if (got_v() !== exp_v) begin
        errors++; $display("FAIL test_reset cyc %0d: got %h exp %h", i, got_v(), exp_v);
      end
    end
  endtask

  task automatic test_scan();
    reset_n = 1'b1; bus.digits = 16'h1234; bus.dp = 4'h0; bus.brightness = 3'd7;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick(); vectors++;
      if (got_v() !== exp_v) begin
        errors++; $display("FAIL test_scan cyc %0d: got %h exp %h", i, got_v(), exp_v);
      end
    end
  endtask

  task automatic test_midframe();
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i == 10) bus.digits = 16'hABCD;
      tick(); vectors++;
      if (got_v() !== exp_v) begin
        errors++; $display("FAIL test_midframe cyc %0d: got %h exp %h", i, got_v(), exp_v);
      end
    end
  endtask

  task automatic test_brightness();
    for (int b = 0; b < (1 << BW); b++) begin
      bus.brightness = BW'(b);
      for (int i = 0; i < 2 * FRAME; i++) begin
        tick(); vectors++;
        if (got_v() !== exp_v) begin
          errors++;
          $display("FAIL test_brightness b=%0d cyc %0d: got %h exp %h", b, i, got_v(), exp_v);
        end
      end
    end
  endtask

  task automatic test_blank_dp();
    bus.blank = 4'b0100; bus.dp = 4'b0001; bus.brightness = 3'd7;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(); vectors++;
      if (got_v() !== exp_v) begin
        errors++; $display("FAIL test_blank_dp cyc %0d: got %h exp %h", i, got_v(), exp_v);
      end
    end
  endtask

  task automatic test_enable();
    for (int i = 0; i < 70; i++) begin
      bus.enable = !(i >= 13 && i < 33);
      tick(); vectors++;
      if (got_v() !== exp_v) begin
        errors++; $display("FAIL test_enable cyc %0d: got %h exp %h", i, got_v(), exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 60; i++) begin
      reset_n = (i != 17);
      tick(); vectors++;
      if (got_v() !== exp_v) begin
        errors++; $display("FAIL test_reset_mid cyc %0d: got %h exp %h", i, got_v(), exp_v);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      reset_n        = ($urandom_range(0, 299) != 0);
      bus.enable     = ($urandom_range(0, 7) != 0);
      bus.digits     = 16'(32'($urandom));
      bus.dp         = 4'(32'($urandom));
      bus.blank      = ($urandom_range(0, 3) == 0) ? 4'(32'($urandom)) : 4'h0;
      bus.brightness = 3'(32'($urandom));
      tick(); vectors++;
      if (got_v() !== exp_v) begin
        errors++; $display("FAIL test_random cyc %0d: got %h exp %h", i, got_v(), exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_midframe();
    test_brightness();
    test_blank_dp();
    test_enable();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
